// File: rtl/fetch.sv
// Instruction-fetch stage of the pipelined Beta core: owns the fetch PC, runs the
// single-outstanding imem handshake, and resolves next-PC from decode and exceptions.
module fetch #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
  parameter logic [31:0] NOP_INST  = 32'h83FF_F800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        op_jmp,
  input  logic        op_beq,
  input  logic        op_bne,
  input  logic        zr,
  input  logic [31:0] j_addr,
  input  logic [31:0] br_addr,
  output logic [31:0] pc,
  output logic [31:0] ir
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic [31:0] seq_pc_s;
  logic [31:0] target_s;
  logic        taken_s;
  logic        redirect_s;
  logic        req_s;
  logic        valid_s;
  logic        unused_s;

  assign unused_s  = ^{j_addr[1:0], br_addr[1:0]};
  assign imem_addr = fetch_pc_q;
  assign imem_req  = req_s;

  always_comb begin
    // Sequential increment keeps the supervisor bit untouched.
    seq_pc_s   = {fetch_pc_q[31], fetch_pc_q[30:0] + 31'd4};
    taken_s    = op_jmp | (op_beq & zr) | (op_bne & ~zr);
    redirect_s = ~stall & (exc_req | taken_s);
    if (exc_req) begin
      target_s = EXC_VEC;
    end else if (op_jmp) begin
      target_s = {fetch_pc_q[31] & j_addr[31], j_addr[30:2], 2'b00};
    end else begin
      target_s = {fetch_pc_q[31], br_addr[30:2], 2'b00};
    end
    req_s   = ~rst & (state_q != HOLD);
    valid_s = imem_valid & req_s;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    hold_ir_d  = hold_ir_q;
    hold_pc_d  = hold_pc_q;
    redir_pc_d = redir_pc_q;
    ir         = NOP_INST;
    pc         = seq_pc_s;

    case (state_q)
      FETCH: begin
        if (valid_s) begin
          if (stall) begin
            hold_ir_d = imem_rdata;
            hold_pc_d = seq_pc_s;
            state_d   = HOLD;
          end else if (redirect_s) begin
            fetch_pc_d = target_s;
          end else begin
            ir         = imem_rdata;
            fetch_pc_d = seq_pc_s;
          end
        end else if (redirect_s) begin
          redir_pc_d = target_s;
          state_d    = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (stall) begin
          state_d = HOLD;
        end else if (redirect_s) begin
          fetch_pc_d = target_s;
          state_d    = FETCH;
        end else begin
          ir         = hold_ir_q;
          pc         = hold_pc_q;
          fetch_pc_d = seq_pc_s;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        // The response still owed for the old address is thrown away.
        if (valid_s) begin
          fetch_pc_d = redirect_s ? target_s : redir_pc_q;
          state_d    = FETCH;
        end else if (redirect_s) begin
          redir_pc_d = target_s;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_VEC;
      hold_ir_q  <= 32'h0000_0000;
      hold_pc_q  <= 32'h0000_0000;
      redir_pc_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hold_ir_q  <= hold_ir_d;
      hold_pc_q  <= hold_pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a memory model echoes the address as data after a
// programmable number of wait cycles; expectations are hand-computed.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h83FF_F800;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        exc_req;
  logic        op_jmp;
  logic        op_beq;
  logic        op_bne;
  logic        zr;
  logic [31:0] j_addr;
  logic [31:0] br_addr;
  logic [31:0] pc;
  logic [31:0] ir;

  int checks;
  int errors;
  int waits;
  int wait_cnt;

  fetch dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall      (stall),
    .exc_req    (exc_req),
    .op_jmp     (op_jmp),
    .op_beq     (op_beq),
    .op_bne     (op_bne),
    .zr         (zr),
    .j_addr     (j_addr),
    .br_addr    (br_addr),
    .pc         (pc),
    .ir         (ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_addr;
  assign imem_valid = imem_req && (wait_cnt >= waits);

  // Memory model: count wait cycles of the current request.
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && imem_valid) wait_cnt <= 0;
    else if (imem_req) wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    op_jmp = 1'b0; op_beq = 1'b0; op_bne = 1'b0; zr = 1'b0;
    exc_req = 1'b0; stall = 1'b0;
  endtask

  task automatic fetched(input string tag, input logic [31:0] a);
    #1;
    check({tag, "_addr"}, imem_addr, a);
    check({tag, "_ir"}, ir, a);
    check({tag, "_pc"}, pc, a + 32'd4);
  endtask

  initial begin
    checks = 0; errors = 0; waits = 0;
    rst = 1'b1; stall = 1'b0; exc_req = 1'b0;
    op_jmp = 1'b0; op_beq = 1'b0; op_bne = 1'b0; zr = 1'b0;
    j_addr = 32'h0000_0000; br_addr = 32'h0000_0000;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_ir", ir, NOP);
    check("rst_pc", pc, 32'h8000_0004);
    check("rst_addr", imem_addr, 32'h8000_0000);
    rst = 1'b0;

    // Zero-wait streaming
    fetched("seq0", 32'h8000_0000);
    cyc; fetched("seq1", 32'h8000_0004);
    cyc; fetched("seq2", 32'h8000_0008);

    // Two wait states
    cyc; waits = 2; #1;
    check("w0_ir", ir, NOP);
    check("w0_addr", imem_addr, 32'h8000_000C);
    check("w0_pc", pc, 32'h8000_0010);
    cyc; #1;
    check("w1_ir", ir, NOP);
    check("w1_addr", imem_addr, 32'h8000_000C);
    cyc; fetched("w2", 32'h8000_000C);

    // Taken BEQ annuls the concurrent fetch
    cyc; waits = 0; op_beq = 1'b1; zr = 1'b1; br_addr = 32'h0000_0100; #1;
    check("beq_addr", imem_addr, 32'h8000_0010);
    check("beq_ir", ir, NOP);
    check("beq_pc", pc, 32'h8000_0014);
    cyc; fetched("beq_tgt", 32'h8000_0100);
    // Same branch, not taken
    cyc; op_beq = 1'b1; zr = 1'b0; fetched("beqnt", 32'h8000_0104);
    cyc; fetched("beqnt_nx", 32'h8000_0108);

    // Stall for three cycles coincident with valid
    cyc; stall = 1'b1; #1;
    check("st0_ir", ir, NOP);
    check("st0_addr", imem_addr, 32'h8000_010C);
    cyc; stall = 1'b1; #1;
    check("st1_req", {31'd0, imem_req}, 32'd0);
    check("st1_ir", ir, NOP);
    cyc; stall = 1'b1; #1;
    check("st2_req", {31'd0, imem_req}, 32'd0);
    check("st2_ir", ir, NOP);
    cyc; #1;
    check("st3_ir", ir, 32'h8000_010C);
    check("st3_pc", pc, 32'h8000_0110);
    check("st3_req", {31'd0, imem_req}, 32'd0);
    cyc; fetched("st_nx", 32'h8000_0110);

    // JMP clears supervisor bit, then cannot set it again
    cyc; op_jmp = 1'b1; j_addr = 32'h0000_0040; #1;
    check("j0_ir", ir, NOP);
    cyc; op_jmp = 1'b1; j_addr = 32'h8000_0200; #1;
    check("j1_addr", imem_addr, 32'h0000_0040);
    check("j1_ir", ir, NOP);
    cyc; fetched("j1_tgt", 32'h0000_0200);
    // Exception restores supervisor mode
    cyc; exc_req = 1'b1; #1;
    check("exc_ir", ir, NOP);
    cyc; op_jmp = 1'b1; j_addr = 32'h8000_0040; #1;
    check("exc_addr", imem_addr, 32'h8000_0008);
    cyc; op_jmp = 1'b1; j_addr = 32'h8000_0200; #1;
    check("j2_addr", imem_addr, 32'h8000_0040);
    cyc; fetched("j2_tgt", 32'h8000_0200);

    // Branch taken during a two-cycle wait: drain the old response
    cyc; waits = 2; op_beq = 1'b1; zr = 1'b1; br_addr = 32'h0000_0300; #1;
    check("dr0_addr", imem_addr, 32'h8000_0204);
    check("dr0_ir", ir, NOP);
    cyc; #1;
    check("dr1_addr", imem_addr, 32'h8000_0204);
    check("dr1_req", {31'd0, imem_req}, 32'd1);
    check("dr1_ir", ir, NOP);
    cyc; #1;
    check("dr2_valid", {31'd0, imem_valid}, 32'd1);
    check("dr2_ir", ir, NOP);
    cyc; waits = 0; fetched("dr_tgt", 32'h8000_0300);

    // Exception beats a taken jump
    cyc; op_jmp = 1'b1; j_addr = 32'h8000_0400; exc_req = 1'b1; #1;
    check("ej_ir", ir, NOP);
    cyc; fetched("ej_tgt", 32'h8000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
